// File: rtl/gpio_ctrl_arb.sv
// Two-requester arbiter in front of a GPIO slave. Keeps shadow copies of the
// slave data_out/data_dir registers so masked writes need no read-back.
module gpio_ctrl_arb #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  input  logic [31:0] req_mask0,
  input  logic [31:0] req_mask1,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_WR_OUT = 2'b01;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_id;
  logic [1:0]  r_op;
  logic [31:0] r_sh_out;
  logic [31:0] r_sh_dir;

  logic        w_win;
  logic        w_accept;
  logic [1:0]  w_op;
  logic [31:0] w_mask;
  logic [31:0] w_data;
  logic        w_is_write;
  logic [31:0] w_shadow;
  logic [31:0] w_merged;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_win = 1'b0;
    if (PRIO_FIXED != 0)
      w_win = ~req_valid[0];
    else if (&req_valid)
      w_win = ~r_last_grant;
    else
      w_win = req_valid[1];

    req_ready = 2'b00;
    if (r_state == ST_IDLE && (|req_valid))
      req_ready = w_win ? 2'b10 : 2'b01;
  end

  assign w_accept   = |(req_valid & req_ready);
  assign w_op       = w_win ? req_op1   : req_op0;
  assign w_mask     = w_win ? req_mask1 : req_mask0;
  assign w_data     = w_win ? req_data1 : req_data0;
  assign w_is_write = w_op[0] ^ w_op[1];
  assign w_shadow   = (w_op == OP_WR_OUT) ? r_sh_out : r_sh_dir;
  assign w_merged   = (w_shadow & ~w_mask) | (w_data & w_mask);

  // The merged write word is formed at accept time; the shadows cannot change
  // before the WRITE cycle, so the registered bus word is exact.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= 2'b00;
      r_sh_out     <= '0;
      r_sh_dir     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      m_address    <= 2'd0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id         <= w_win;
            r_last_grant <= w_win;
            r_op         <= w_op;
            m_address    <= {1'b0, w_op[1]};
            m_chipselect <= 1'b1;
            m_write_n    <= ~w_is_write;
            m_writedata  <= w_is_write ? w_merged : '0;
            r_state      <= w_is_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (r_op == OP_WR_OUT)
            r_sh_out <= m_writedata;
          else
            r_sh_dir <= m_writedata;
          rsp_data     <= m_writedata;
          rsp_valid    <= 1'b1;
          rsp_id       <= r_id;
          m_address    <= 2'd0;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          m_writedata  <= '0;
          r_state      <= ST_DONE;
        end
        ST_READ: begin
          r_state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          rsp_data     <= m_readdata;
          rsp_valid    <= 1'b1;
          rsp_id       <= r_id;
          m_address    <= 2'd0;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          rsp_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_ctrl_arb.sv
// Directed bench for gpio_ctrl_arb: round-robin DUT with a GPIO slave model,
// plus a fixed-priority DUT sharing the request inputs for the tie test.
module tb_gpio_ctrl_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_mask0, req_mask1, req_data0, req_data1;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [31:0] m_writedata, m_readdata;

  logic [1:0]  req_ready_f;
  logic        rsp_valid_f, rsp_id_f;
  logic [31:0] rsp_data_f;
  logic [1:0]  m_address_f;
  logic        m_chipselect_f, m_write_n_f;
  logic [31:0] m_writedata_f;
  logic [31:0] m_readdata_f;

  logic [31:0] sl_pins, sl_out, sl_dir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_ctrl_arb #(.PRIO_FIXED(0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_mask0(req_mask0), .req_mask1(req_mask1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

  gpio_ctrl_arb #(.PRIO_FIXED(1)) dut_fixed (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_mask0(req_mask0), .req_mask1(req_mask1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready_f), .rsp_valid(rsp_valid_f), .rsp_id(rsp_id_f),
    .rsp_data(rsp_data_f), .m_address(m_address_f),
    .m_chipselect(m_chipselect_f), .m_write_n(m_write_n_f),
    .m_writedata(m_writedata_f), .m_readdata(m_readdata_f)
  );

  assign m_readdata_f = 32'h0;

  // GPIO slave: registered read data, address 0 reads the pins.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sl_out     <= '0;
      sl_dir     <= '0;
      m_readdata <= '0;
    end else if (m_chipselect) begin
      if (!m_write_n) begin
        if (m_address == 2'd0) sl_out <= m_writedata;
        else                   sl_dir <= m_writedata;
      end else begin
        m_readdata <= (m_address == 2'd0) ? sl_pins : sl_dir;
      end
    end
  end

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_req(input int id, input logic [1:0] op,
                        input logic [31:0] mask, input logic [31:0] data,
                        output int lat, output logic rid,
                        output logic [31:0] rdata, output int nwr,
                        output logic [1:0] waddr, output logic [31:0] wdata);
    int t;
    lat = 99; rid = 1'b0; rdata = '0; nwr = 0; waddr = 2'd0; wdata = '0;
    @(negedge clk);
    if (id == 0) begin req_op0 = op; req_mask0 = mask; req_data0 = data; end
    else         begin req_op1 = op; req_mask1 = mask; req_data1 = data; end
    req_valid[id] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[id] && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (!req_ready[id]) begin
      checks++; errors++;
      $display("FAIL grant_timeout requester %0d never got req_ready", id);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (m_chipselect && !m_write_n) begin
        nwr++; waddr = m_address; wdata = m_writedata;
      end
      if (rsp_valid) begin
        lat = c; rid = rsp_id; rdata = rsp_data;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse_width rsp_valid=%b want 0 one cycle later", rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id got %b want 0", rsp_id); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", m_chipselect); end
    checks++; if (m_write_n !== 1'b1) begin errors++; $display("FAIL rst_write_n got %b want 1", m_write_n); end
    checks++; if (m_address !== 2'd0) begin errors++; $display("FAIL rst_address got %0d want 0", m_address); end
    checks++; if (m_writedata !== 32'h0) begin errors++; $display("FAIL rst_writedata got %h want 0", m_writedata); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready_novalid got %b want 00", req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_tie got %b want 01", req_ready); end
    checks++; if (req_ready_f !== 2'b01) begin errors++; $display("FAIL rst_first_tie_fixed got %b want 01", req_ready_f); end
    req_valid = 2'b00;
  endtask

  task automatic test_arb_tie();
    logic g0 [4];
    logic g1 [4];
    logic exp_rr [4];
    int n0, n1, t;
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    n0 = 0; n1 = 0; t = 0;
    @(negedge clk);
    req_op0 = 2'b11; req_op1 = 2'b11;
    req_mask0 = '0; req_mask1 = '0;
    req_valid = 2'b11;
    #1;
    while ((n0 < 4 || n1 < 4) && t < 80) begin
      if (req_ready != 2'b00 && n0 < 4) begin g0[n0] = req_ready[1]; n0++; end
      if (req_ready_f != 2'b00 && n1 < 4) begin g1[n1] = req_ready_f[1]; n1++; end
      @(negedge clk); #1; t++;
    end
    req_valid = 2'b00;
    checks++;
    if (n0 < 4 || n1 < 4) begin
      errors++;
      $display("FAIL tie_timeout grants seen rr=%0d fixed=%0d want 4 each", n0, n1);
    end
    for (int i = 0; i < n0; i++) begin
      checks++;
      if (g0[i] !== exp_rr[i]) begin errors++; $display("FAIL tie_rr grant %0d got %b want %b", i, g0[i], exp_rr[i]); end
    end
    for (int i = 0; i < n1; i++) begin
      checks++;
      if (g1[i] !== 1'b0) begin errors++; $display("FAIL tie_fixed grant %0d got %b want 0", i, g1[i]); end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_masked_write();
    int lat, nwr; logic rid; logic [31:0] rdata, wdata; logic [1:0] waddr;
    do_req(0, 2'b10, 32'hFFFF_FFFF, 32'h0000_00FF, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dir_wr_latency got %0d want 2", lat); end
    checks++; if (nwr !== 1 || waddr !== 2'd1 || wdata !== 32'h0000_00FF) begin errors++; $display("FAIL dir_wr_bus n=%0d addr=%0d data=%h want 1/1/000000ff", nwr, waddr, wdata); end
    checks++; if (rid !== 1'b0 || rdata !== 32'h0000_00FF) begin errors++; $display("FAIL dir_wr_rsp id=%b data=%h want 0/000000ff", rid, rdata); end
    do_req(0, 2'b01, 32'h0000_000F, 32'h0000_0005, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (lat !== 2) begin errors++; $display("FAIL out_wr_latency got %0d want 2", lat); end
    checks++; if (nwr !== 1 || waddr !== 2'd0 || wdata !== 32'h0000_0005) begin errors++; $display("FAIL out_wr_bus n=%0d addr=%0d data=%h want 1/0/00000005", nwr, waddr, wdata); end
    checks++; if (sl_dir !== 32'h0000_00FF || sl_out !== 32'h0000_0005) begin errors++; $display("FAIL slave_regs dir=%h out=%h want 000000ff/00000005", sl_dir, sl_out); end
  endtask

  task automatic test_rmw();
    int lat, nwr; logic rid; logic [31:0] rdata, wdata; logic [1:0] waddr;
    do_req(1, 2'b01, 32'h0000_00F0, 32'h0000_00A0, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (nwr !== 1 || waddr !== 2'd0 || wdata !== 32'h0000_00A5) begin errors++; $display("FAIL rmw_bus n=%0d addr=%0d data=%h want 1/0/000000a5", nwr, waddr, wdata); end
    checks++; if (rid !== 1'b1) begin errors++; $display("FAIL rmw_rsp_id got %b want 1", rid); end
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL rmw_rsp_data got %h want 000000a5", rdata); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rmw_latency got %0d want 2", lat); end
  endtask

  task automatic test_zero_mask();
    int lat, nwr; logic rid; logic [31:0] rdata, wdata; logic [1:0] waddr;
    for (int k = 0; k < 2; k++) begin
      do_req(0, 2'b01, 32'h0, 32'hFFFF_FFFF, lat, rid, rdata, nwr, waddr, wdata);
      checks++; if (nwr !== 1 || waddr !== 2'd0 || wdata !== 32'h0000_00A5) begin errors++; $display("FAIL zmask_out_%0d n=%0d addr=%0d data=%h want 1/0/000000a5", k, nwr, waddr, wdata); end
    end
    do_req(1, 2'b10, 32'h0, 32'h1234_0000, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (nwr !== 1 || waddr !== 2'd1 || wdata !== 32'h0000_00FF) begin errors++; $display("FAIL zmask_dir n=%0d addr=%0d data=%h want 1/1/000000ff", nwr, waddr, wdata); end
  endtask

  task automatic test_pin_read();
    int lat, nwr; logic rid; logic [31:0] rdata, wdata; logic [1:0] waddr;
    sl_pins = 32'h1234_5678;
    do_req(0, 2'b00, 32'h0, 32'h0, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (lat !== 3) begin errors++; $display("FAIL pin_rd_latency got %0d want 3", lat); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL pin_rd_data got %h want 12345678", rdata); end
    checks++; if (nwr !== 0 || rid !== 1'b0) begin errors++; $display("FAIL pin_rd_misc writes=%0d id=%b want 0/0", nwr, rid); end
    do_req(1, 2'b11, 32'h0, 32'h0, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (lat !== 3 || rdata !== 32'h0000_00FF || rid !== 1'b1) begin errors++; $display("FAIL dir_rd lat=%0d data=%h id=%b want 3/000000ff/1", lat, rdata, rid); end
  endtask

  task automatic test_reset_in_write();
    int lat, nwr, t; logic rid; logic [31:0] rdata, wdata; logic [1:0] waddr;
    @(negedge clk);
    req_op0 = 2'b01; req_mask0 = 32'hFFFF_FFFF; req_data0 = 32'hDEAD_BEEF;
    req_valid = 2'b01;
    #1;
    t = 0;
    while (!req_ready[0] && t < 20) begin @(negedge clk); #1; t++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0) begin errors++; $display("FAIL rstw_in_write cs=%b wn=%b want 1/0", m_chipselect, m_write_n); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'h0) begin errors++; $display("FAIL rstw_bus_idle cs=%b wn=%b wd=%h want 0/1/0", m_chipselect, m_write_n, m_writedata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_rsp cycle %0d rsp_valid=%b want 0", c, rsp_valid); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstw_ready got %b want 01", req_ready); end
    req_valid = 2'b00;
    do_req(0, 2'b01, 32'h0, 32'hFFFF_FFFF, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (nwr !== 1 || wdata !== 32'h0 || lat !== 2) begin errors++; $display("FAIL rstw_sh_out n=%0d data=%h lat=%0d want 1/0/2", nwr, wdata, lat); end
    do_req(0, 2'b10, 32'h0, 32'hFFFF_FFFF, lat, rid, rdata, nwr, waddr, wdata);
    checks++; if (nwr !== 1 || wdata !== 32'h0 || waddr !== 2'd1) begin errors++; $display("FAIL rstw_sh_dir n=%0d data=%h addr=%0d want 1/0/1", nwr, wdata, waddr); end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_mask0 = '0; req_mask1 = '0; req_data0 = '0; req_data1 = '0;
    sl_pins = 32'h0;
    test_reset();
    test_arb_tie();
    apply_reset();
    test_masked_write();
    test_rmw();
    test_zero_mask();
    test_pin_read();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
